brush_stroke_expander: RTL and testbench

- Parametrised successor to the single-pixel brush/symmetry expander in the drawing pipeline.
- Accepts one pixel command per stroke point over a valid/ready input handshake.
- Expands it into a square or diamond brush footprint, with optional 2-way or 4-way mirror symmetry and optional canvas clipping.
- Streams the resulting pixels one per beat over a valid/ready output to the I2C/display transmit stage.

---
 rtl/brush_stroke_expander_if.sv | 31 +++
 rtl/brush_stroke_expander.sv | 130 +++++++++++++
 tb/tb_brush_stroke_expander.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/brush_stroke_expander_if.sv
// Stroke-command input and pixel-stream output of the brush stroke expander.
// The expander itself connects through the slave modport.
interface brush_stroke_expander_if #(
  parameter int COORD_W = 8,
  parameter int SIZE_W  = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] x_in;
  logic [COORD_W-1:0] y_in;
  logic [SIZE_W-1:0]  brush_size;
  logic               shape;
  logic [1:0]         symmetry_mode;
  logic               clip_en;
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] x_out;
  logic [COORD_W-1:0] y_out;
  logic               busy;
  logic               done;

  modport slave (
    input  in_valid, x_in, y_in, brush_size, shape, symmetry_mode, clip_en, out_ready,
    output in_ready, out_valid, x_out, y_out, busy, done
  );

  modport master (
    output in_valid, x_in, y_in, brush_size, shape, symmetry_mode, clip_en, out_ready,
    input  in_ready, out_valid, x_out, y_out, busy, done
  );
endinterface

// File: rtl/brush_stroke_expander.sv
// Expands one stroke point into a square/diamond brush footprint with optional
// mirror symmetry and canvas clipping, streaming one pixel per output beat.
module brush_stroke_expander #(
  parameter int COORD_W    = 8,
  parameter int SIZE_W     = 3,
  parameter int CANVAS_MAX = 2**COORD_W - 1
) (
  input logic clk,
  input logic rst_n,
  brush_stroke_expander_if.slave bus
);
  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'(CANVAS_MAX);

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  state_t r_state, w_nextState;

  logic [COORD_W-1:0] r_baseX, r_baseY, r_xOut, r_yOut;
  logic [SIZE_W-1:0]  r_size, r_dx, r_dy;
  logic               r_shape, r_clip, r_outValid, r_done;
  logic [1:0]         r_symMode, r_symIdx;

  logic               w_outFree, w_accept, w_step, w_drainDone, w_lastCand, w_skip;
  logic               w_mirrorX, w_mirrorY;
  logic [1:0]         w_lastSym;
  logic signed [SW-1:0] w_h, w_offX, w_offY, w_absX, w_absY, w_px, w_py;
  logic [COORD_W-1:0] w_wrapX, w_wrapY, w_candX, w_candY;

  assign w_outFree = !r_outValid || bus.out_ready;

  // Candidate arithmetic: offsets are centred on h, the diamond test uses the
  // unmirrored offsets so every mirror copy of a point is kept or dropped together.
  always_comb begin
    w_h       = SW'(r_size >> 1);
    w_offX    = $signed(SW'(r_dx)) - w_h;
    w_offY    = $signed(SW'(r_dy)) - w_h;
    w_absX    = w_offX[SW-1] ? -w_offX : w_offX;
    w_absY    = w_offY[SW-1] ? -w_offY : w_offY;
    w_px      = $signed(SW'(r_baseX)) + w_offX;
    w_py      = $signed(SW'(r_baseY)) + w_offY;
    w_skip    = (r_shape && ((w_absX + w_absY) > w_h)) ||
                (r_clip && (w_px[SW-1] || w_py[SW-1] || (w_px > MAX_S) || (w_py > MAX_S)));
    w_mirrorX = ((r_symMode == 2'd1) && (r_symIdx == 2'd1)) || ((r_symMode == 2'd3) && r_symIdx[0]);
    w_mirrorY = ((r_symMode == 2'd2) && (r_symIdx == 2'd1)) || ((r_symMode == 2'd3) && r_symIdx[1]);
    w_wrapX   = w_px[COORD_W-1:0];
    w_wrapY   = w_py[COORD_W-1:0];
    w_candX   = w_mirrorX ? COORD_W'(CANVAS_MAX) - w_wrapX : w_wrapX;
    w_candY   = w_mirrorY ? COORD_W'(CANVAS_MAX) - w_wrapY : w_wrapY;
    w_lastSym = (r_symMode == 2'd0) ? 2'd0 : ((r_symMode == 2'd3) ? 2'd3 : 2'd1);
    w_lastCand = (r_symIdx == w_lastSym) && (r_dx == r_size) && (r_dy == r_size);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_drainDone = 1'b0;
    case (r_state)
      IDLE: if (bus.in_valid) begin
        w_accept    = 1'b1;
        w_nextState = GEN;
      end
      GEN: if (w_outFree) begin
        w_step = 1'b1;
        if (w_lastCand) w_nextState = DRAIN;
      end
      DRAIN: if (w_outFree) begin
        w_drainDone = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Iteration order: symmetry copy fastest, then dx, then dy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_baseX <= '0; r_baseY <= '0; r_size <= '0; r_shape <= 1'b0;
      r_symMode <= '0; r_clip <= 1'b0; r_dx <= '0; r_dy <= '0; r_symIdx <= '0;
      r_xOut <= '0; r_yOut <= '0; r_outValid <= 1'b0; r_done <= 1'b0;
    end else begin
      r_done <= w_drainDone;
      if (w_accept) begin
        r_baseX   <= bus.x_in;
        r_baseY   <= bus.y_in;
        r_size    <= bus.brush_size;
        r_shape   <= bus.shape;
        r_symMode <= bus.symmetry_mode;
        r_clip    <= bus.clip_en;
        r_dx      <= '0;
        r_dy      <= '0;
        r_symIdx  <= '0;
      end
      if (w_step) begin
        if (w_skip) begin
          r_outValid <= 1'b0;
        end else begin
          r_outValid <= 1'b1;
          r_xOut     <= w_candX;
          r_yOut     <= w_candY;
        end
        if (r_symIdx != w_lastSym) begin
          r_symIdx <= r_symIdx + 2'd1;
        end else begin
          r_symIdx <= '0;
          if (r_dx != r_size) begin
            r_dx <= r_dx + 1'b1;
          end else begin
            r_dx <= '0;
            if (r_dy != r_size) r_dy <= r_dy + 1'b1;
          end
        end
      end
      if (w_drainDone) r_outValid <= 1'b0;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_outValid;
  assign bus.x_out     = r_xOut;
  assign bus.y_out     = r_yOut;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_brush_stroke_expander.sv
// Directed, table-driven bench for brush_stroke_expander: each stroke's pixel
// sequence is hand-computed, plus reset, stall and busy-ignore sequences.
module tb_brush_stroke_expander;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  brush_stroke_expander_if #(.COORD_W(8), .SIZE_W(3)) bus ();

  brush_stroke_expander #(.COORD_W(8), .SIZE_W(3), .CANVAS_MAX(255)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0]      x;
    logic [7:0]      y;
    logic [2:0]      size;
    logic            shape;
    logic [1:0]      sym;
    logic            clip;
    logic [7:0]      stallAt;
    logic            poke;
    logic            firstHit;
    logic [7:0]      nBeats;
    logic [8:0][7:0] ex;
    logic [8:0][7:0] ey;
  } vec_t;

  vec_t       vecs[10];
  int         nVec = 0;
  int         checks = 0;
  int         passes = 0;
  logic [7:0] rx[64];
  logic [7:0] ry[64];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic addVec(input logic [7:0] x, input logic [7:0] y, input logic [2:0] size,
                        input logic shape, input logic [1:0] sym, input logic clip,
                        input logic [7:0] stallAt, input logic poke, input logic firstHit);
    vecs[nVec]          = '0;
    vecs[nVec].x        = x;
    vecs[nVec].y        = y;
    vecs[nVec].size     = size;
    vecs[nVec].shape    = shape;
    vecs[nVec].sym      = sym;
    vecs[nVec].clip     = clip;
    vecs[nVec].stallAt  = stallAt;
    vecs[nVec].poke     = poke;
    vecs[nVec].firstHit = firstHit;
    nVec++;
  endtask

  task automatic addPix(input logic [7:0] x, input logic [7:0] y);
    vecs[nVec-1].ex[vecs[nVec-1].nBeats] = x;
    vecs[nVec-1].ey[vecs[nVec-1].nBeats] = y;
    vecs[nVec-1].nBeats++;
  endtask

  task automatic applyStimulus(input int vi);
    int   beats;
    int   stalls;
    logic gotDone;
    logic [16:0] snap;
    beats   = 0;
    stalls  = 0;
    gotDone = 1'b0;
    snap    = '0;
    bus.x_in          = vecs[vi].x;
    bus.y_in          = vecs[vi].y;
    bus.brush_size    = vecs[vi].size;
    bus.shape         = vecs[vi].shape;
    bus.symmetry_mode = vecs[vi].sym;
    bus.clip_en       = vecs[vi].clip;
    bus.in_valid      = 1'b1;
    bus.out_ready     = 1'b1;
    checkOutput($sformatf("in_ready before vec %0d", vi), 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble the command inputs to show the stroke uses latched values.
    bus.in_valid      = 1'b0;
    bus.x_in          = 8'hAA;
    bus.y_in          = 8'h55;
    bus.brush_size    = 3'd7;
    bus.shape         = ~vecs[vi].shape;
    bus.symmetry_mode = ~vecs[vi].sym;
    bus.clip_en       = ~vecs[vi].clip;
    for (int iter = 0; iter < 300 && !gotDone; iter++) begin
      if (iter == 0) begin
        checkOutput($sformatf("busy at start vec %0d", vi), 32'(bus.busy), 32'd1);
        checkOutput($sformatf("out_valid at start vec %0d", vi), 32'(bus.out_valid), 32'd0);
      end
      if (iter == 1 && vecs[vi].firstHit)
        checkOutput($sformatf("first beat latency vec %0d", vi), 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      if (vecs[vi].stallAt != 0 && beats == int'(vecs[vi].stallAt) && stalls < 3) begin
        bus.out_ready = 1'b0;
        if (stalls == 0) snap = {bus.out_valid, bus.x_out, bus.y_out};
        else checkOutput($sformatf("held during stall %0d", stalls), 32'({bus.out_valid, bus.x_out, bus.y_out}), 32'(snap));
        stalls++;
      end
      if (vecs[vi].poke && iter == 2) begin
        bus.in_valid = 1'b1;
        bus.x_in     = 8'd77;
        checkOutput("in_ready while busy", 32'(bus.in_ready), 32'd0);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.done) begin
        gotDone = 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        if (beats < 64) begin
          rx[beats] = bus.x_out;
          ry[beats] = bus.y_out;
        end
        beats++;
      end
      if (!gotDone) begin
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
    if (!gotDone) begin
      checkOutput($sformatf("done timeout vec %0d", vi), 32'd0, 32'd1);
      return;
    end
    checkOutput($sformatf("out_valid at done vec %0d", vi), 32'(bus.out_valid), 32'd0);
    checkOutput($sformatf("in_ready at done vec %0d", vi), 32'(bus.in_ready), 32'd1);
    checkOutput($sformatf("beat count vec %0d", vi), 32'(beats), 32'(vecs[vi].nBeats));
    for (int k = 0; k < int'(vecs[vi].nBeats); k++) begin
      if (k < beats)
        checkOutput($sformatf("pixel %0d vec %0d", k, vi), 32'({rx[k], ry[k]}),
                    32'({vecs[vi].ex[k], vecs[vi].ey[k]}));
    end
    if (vecs[vi].stallAt != 0)
      checkOutput("stall cycles", 32'(stalls), 32'd3);
    @(posedge clk); #1;
    checkOutput($sformatf("done width vec %0d", vi), 32'(bus.done), 32'd0);
    checkOutput($sformatf("busy after vec %0d", vi), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b1;
    bus.x_in          = '0;
    bus.y_in          = '0;
    bus.brush_size    = '0;
    bus.shape         = 1'b0;
    bus.symmetry_mode = '0;
    bus.clip_en       = 1'b0;

    addVec(8'd10, 8'd20, 3'd0, 1'b0, 2'd0, 1'b1, 8'd0, 1'b0, 1'b1);
    addPix(10, 20);
    addVec(8'd100, 8'd50, 3'd2, 1'b0, 2'd0, 1'b1, 8'd0, 1'b0, 1'b1);
    addPix(99, 49); addPix(100, 49); addPix(101, 49);
    addPix(99, 50); addPix(100, 50); addPix(101, 50);
    addPix(99, 51); addPix(100, 51); addPix(101, 51);
    addVec(8'd10, 8'd20, 3'd0, 1'b0, 2'd3, 1'b1, 8'd0, 1'b0, 1'b1);
    addPix(10, 20); addPix(245, 20); addPix(10, 235); addPix(245, 235);
    addVec(8'd10, 8'd20, 3'd0, 1'b0, 2'd1, 1'b1, 8'd0, 1'b0, 1'b1);
    addPix(10, 20); addPix(245, 20);
    addVec(8'd0, 8'd0, 3'd2, 1'b0, 2'd0, 1'b1, 8'd0, 1'b0, 1'b0);
    addPix(0, 0); addPix(1, 0); addPix(0, 1); addPix(1, 1);
    addVec(8'd0, 8'd0, 3'd2, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    addPix(255, 255); addPix(0, 255); addPix(1, 255);
    addPix(255, 0);   addPix(0, 0);   addPix(1, 0);
    addPix(255, 1);   addPix(0, 1);   addPix(1, 1);
    addVec(8'd5, 8'd5, 3'd2, 1'b1, 2'd0, 1'b1, 8'd0, 1'b0, 1'b0);
    addPix(5, 4); addPix(4, 5); addPix(5, 5); addPix(6, 5); addPix(5, 6);
    addVec(8'd200, 8'd30, 3'd1, 1'b0, 2'd2, 1'b1, 8'd0, 1'b0, 1'b1);
    addPix(200, 30); addPix(200, 225); addPix(201, 30); addPix(201, 225);
    addPix(200, 31); addPix(200, 224); addPix(201, 31); addPix(201, 224);
    addVec(8'd100, 8'd50, 3'd2, 1'b0, 2'd0, 1'b1, 8'd3, 1'b1, 1'b1);
    addPix(99, 49); addPix(100, 49); addPix(101, 49);
    addPix(99, 50); addPix(100, 50); addPix(101, 50);
    addPix(99, 51); addPix(100, 51); addPix(101, 51);

    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset xy", 32'({bus.x_out, bus.y_out}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < nVec; v++) applyStimulus(v);

    // Abandon a stroke with reset while a pixel is pending.
    bus.x_in          = 8'd100;
    bus.y_in          = 8'd50;
    bus.brush_size    = 3'd2;
    bus.shape         = 1'b0;
    bus.symmetry_mode = 2'd0;
    bus.clip_en       = 1'b1;
    bus.in_valid      = 1'b1;
    bus.out_ready     = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("pending before reset", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid reset busy", 32'(bus.busy), 32'd0);
    checkOutput("mid reset in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("mid reset xy", 32'({bus.x_out, bus.y_out}), 32'd0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
